// File: rtl/elevator_controller_if.sv
// Floor-queue handshake: the queue (master) presents its head request and
// receives the pop strobe from the cabin sequencer (slave).
interface elevator_controller_if #(
  parameter int FLOOR_W = 2
);
  logic               target_valid;
  logic [FLOOR_W-1:0] target_floor;
  logic               delete_pos0;

  modport master (
    output target_valid,
    output target_floor,
    input  delete_pos0
  );

  modport slave (
    input  target_valid,
    input  target_floor,
    output delete_pos0
  );
endinterface

// File: rtl/elevator_controller.sv
// Cabin sequencer: serves the floor-queue head (move, door open/close, pop).
// Optional macro DOOR_REOPEN_EN: an obstruction during door closing reopens the door.
module elevator_controller #(
  parameter int FLOORS            = 4,
  parameter int FLOOR_W           = 2,
  parameter int TRAVEL_CYCLES     = 50,
  parameter int DOOR_OPEN_CYCLES  = 100,
  parameter int DOOR_CLOSE_CYCLES = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  elevator_controller_if.slave q,
  input  logic                 obstruction,
  output logic [FLOOR_W-1:0]   cur_floor,
  output logic                 motor_up,
  output logic                 motor_down,
  output logic                 door_open,
  output logic                 door_closing,
  output logic                 busy,
  output logic [2:0]           state_o
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_MOVE_UP    = 3'd1;
  localparam logic [2:0] S_MOVE_DOWN  = 3'd2;
  localparam logic [2:0] S_DOOR_OPEN  = 3'd3;
  localparam logic [2:0] S_DOOR_CLOSE = 3'd4;
  localparam logic [2:0] S_RELEASE    = 3'd5;

  localparam int MAX_A = (TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ? TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
  localparam int MAX_C = (MAX_A > DOOR_CLOSE_CYCLES) ? MAX_A : DOOR_CLOSE_CYCLES;
  localparam int TW    = $clog2(MAX_C + 1);

  localparam logic [TW-1:0]      T_TRAVEL = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0]      T_OPEN   = TW'(DOOR_OPEN_CYCLES - 1);
  localparam logic [TW-1:0]      T_CLOSE  = TW'(DOOR_CLOSE_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP      = FLOOR_W'(FLOORS - 1);

  logic [2:0]         state, state_n;
  logic [TW-1:0]      timer, timer_n;
  logic [FLOOR_W-1:0] tgt_q, tgt_n, floor_n;
  logic [FLOOR_W-1:0] route_tgt;
  logic               skip_q, skip_n;
  logic               route;
  logic               req_ok;
  logic               del_q;

  assign req_ok = q.target_valid && (q.target_floor <= TOP);

`ifndef DOOR_REOPEN_EN
  logic unused_obstruction;
  assign unused_obstruction = obstruction;
`endif

  // A "route" decision is taken on request acceptance and at every floor boundary;
  // it picks the direction (or door) from the updated floor and the chosen target.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    floor_n   = cur_floor;
    tgt_n     = tgt_q;
    skip_n    = 1'b0;
    route     = 1'b0;
    route_tgt = tgt_q;

    case (state)
      S_IDLE: begin
        if (req_ok && !skip_q) begin
          route     = 1'b1;
          route_tgt = q.target_floor;
        end
      end

      S_MOVE_UP, S_MOVE_DOWN: begin
        if (timer != '0) begin
          timer_n = timer - 1'b1;
        end else begin
          if (state == S_MOVE_UP)
            floor_n = (cur_floor == TOP) ? cur_floor : cur_floor + 1'b1;
          else
            floor_n = (cur_floor == '0) ? cur_floor : cur_floor - 1'b1;
          route     = 1'b1;
          route_tgt = req_ok ? q.target_floor : tgt_q;
        end
      end

      S_DOOR_OPEN: begin
        if (timer != '0) begin
          timer_n = timer - 1'b1;
        end else begin
          state_n = S_DOOR_CLOSE;
          timer_n = T_CLOSE;
        end
      end

      S_DOOR_CLOSE: begin
`ifdef DOOR_REOPEN_EN
        if (obstruction) begin
          state_n = S_DOOR_OPEN;
          timer_n = T_OPEN;
        end else
`endif
        if (timer != '0) begin
          timer_n = timer - 1'b1;
        end else begin
          state_n = S_RELEASE;
          timer_n = '0;
        end
      end

      // The queue head needs one cycle to update after the pop, hence the skip.
      S_RELEASE: begin
        state_n = S_IDLE;
        skip_n  = 1'b1;
      end

      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase

    if (route) begin
      tgt_n = route_tgt;
      if (route_tgt > floor_n) begin
        state_n = S_MOVE_UP;
        timer_n = T_TRAVEL;
      end else if (route_tgt < floor_n) begin
        state_n = S_MOVE_DOWN;
        timer_n = T_TRAVEL;
      end else begin
        state_n = S_DOOR_OPEN;
        timer_n = T_OPEN;
      end
    end
  end

  // Drive outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      cur_floor    <= '0;
      tgt_q        <= '0;
      skip_q       <= 1'b0;
      motor_up     <= 1'b0;
      motor_down   <= 1'b0;
      door_open    <= 1'b0;
      door_closing <= 1'b0;
      del_q        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      cur_floor    <= floor_n;
      tgt_q        <= tgt_n;
      skip_q       <= skip_n;
      motor_up     <= (state_n == S_MOVE_UP);
      motor_down   <= (state_n == S_MOVE_DOWN);
      door_open    <= (state_n == S_DOOR_OPEN);
      door_closing <= (state_n == S_DOOR_CLOSE);
      del_q        <= (state_n == S_RELEASE);
      busy         <= (state_n != S_IDLE);
    end
  end

  assign q.delete_pos0 = del_q;
  assign state_o       = state;

endmodule
